sobel_grad: RTL

SOBEL_GRAD -- requirements
Module: sobel_grad

---
 rtl/sobel_grad_if.sv | 34 +++
 rtl/sobel_grad.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sobel_grad_if.sv
// rtl/sobel_grad_if.sv - handshake bundle between a Sobel gradient unit and its neighbours
// Purpose: groups the window-in / result-out handshake of sobel_grad.
// Signals:
//   valid_in  - window present on data_in (producer -> unit)
//   busy_out  - unit cannot take a window this cycle (unit -> producer)
//   data_in   - 3x3 window, pixel p[k] at data_in[(9-k)*W-1 -: W]
//   mode_in   - 0 = GX, 1 = GY, 2/3 = MAG
//   valid_out - result present on data_out/sat_out (unit -> consumer)
//   ready_in  - consumer takes the result (consumer -> unit)
//   data_out  - result pixel
//   sat_out   - MAG result was clipped
// Modports: slave = the gradient unit, master = the surrounding logic.
interface sobel_grad_if #(
  parameter int P_DATA_BITS = 8
);
  logic                       valid_in;
  logic                       busy_out;
  logic [9*P_DATA_BITS-1:0]   data_in;
  logic [1:0]                 mode_in;
  logic                       valid_out;
  logic                       ready_in;
  logic [P_DATA_BITS-1:0]     data_out;
  logic                       sat_out;

  modport slave (
    input  valid_in, data_in, mode_in, ready_in,
    output busy_out, valid_out, data_out, sat_out
  );

  modport master (
    output valid_in, data_in, mode_in, ready_in,
    input  busy_out, valid_out, data_out, sat_out
  );
endinterface

// File: rtl/sobel_grad.sv
// rtl/sobel_grad.sv - 3x3 Sobel gradient unit with fixed latency and held result
// Purpose: accepts one 3x3 window, computes GX, GY or clipped |GX|+|GY|
//          magnitude, presents it after P_LATENCY edges and holds it until taken.
// Ports:
//   i_clk   - sole clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   bus     - sobel_grad_if.slave handshake (window in, result out)
// Parameters:
//   P_DATA_BITS - pixel width W (>= 2)
//   P_LATENCY   - edges from accept to valid_out (2..255)
//   P_MAG_SHIFT - right shift applied to the magnitude (0..4)
module sobel_grad #(
  parameter int P_DATA_BITS = 8,
  parameter int P_LATENCY   = 3,
  parameter int P_MAG_SHIFT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  sobel_grad_if.slave bus
);
  // W+4 bits holds any signed gradient (|g| <= 4*(2^W-1)) and the
  // unsigned magnitude sum (<= 8*(2^W-1)).
  localparam int              GW         = P_DATA_BITS + 4;
  localparam logic [7:0]      C_CNT_LOAD = 8'(P_LATENCY - 1);
  // 4*(2^W-1): recentres a signed gradient onto 0..8*(2^W-1)
  localparam logic [GW-1:0]   C_BIAS     = {2'b00, {P_DATA_BITS{1'b1}}, 2'b00};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_HOLD} state_t;

  state_t                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [9*P_DATA_BITS-1:0] win_q, win_d;
  logic [1:0]               mode_q, mode_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic [P_DATA_BITS-1:0]   dout_q, dout_d;
  logic                     sat_q, sat_d;

  logic [P_DATA_BITS-1:0]   pix [9];
  logic [GW-1:0]            gx, gy, ax, ay, mag_sum, mag_shr, lin_sum;
  logic [P_DATA_BITS-1:0]   res_data;
  logic                     res_sat;
  logic                     unused_bits;

  for (genvar k = 0; k < 9; k++) begin : g_pix
    assign pix[k] = win_q[(9-k)*P_DATA_BITS-1 -: P_DATA_BITS];
  end

  // Arithmetic is done modulo 2^GW; the MSB of gx/gy is the sign.
  always_comb begin
    gx = (GW'(pix[0]) + (GW'(pix[3]) << 1) + GW'(pix[6]))
       - (GW'(pix[2]) + (GW'(pix[5]) << 1) + GW'(pix[8]));
    gy = (GW'(pix[0]) + (GW'(pix[1]) << 1) + GW'(pix[2]))
       - (GW'(pix[6]) + (GW'(pix[7]) << 1) + GW'(pix[8]));
    ax = gx[GW-1] ? (-gx) : gx;
    ay = gy[GW-1] ? (-gy) : gy;
    mag_sum = ax + ay;
    mag_shr = mag_sum >> P_MAG_SHIFT;
    lin_sum = (mode_q[0] ? gy : gx) + C_BIAS;
    if (mode_q[1]) begin
      res_sat  = |mag_shr[GW-1:P_DATA_BITS];
      res_data = res_sat ? {P_DATA_BITS{1'b1}} : mag_shr[P_DATA_BITS-1:0];
    end else begin
      res_sat  = 1'b0;
      res_data = lin_sum[P_DATA_BITS+2:3];
    end
  end

  // lin_sum never exceeds 8*(2^W-1), so its top bit and the bits
  // dropped by the >>3 carry no information.
  assign unused_bits = ^{lin_sum[GW-1], lin_sum[2:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    dout_d  = dout_q;
    sat_d   = sat_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.valid_in) begin
          state_d = S_CALC;
          cnt_d   = C_CNT_LOAD;
          win_d   = bus.data_in;
          mode_d  = bus.mode_in;
          busy_d  = 1'b1;
        end
      end
      S_CALC: begin
        if (cnt_q == 8'd0) begin
          state_d = S_HOLD;
          valid_d = 1'b1;
          dout_d  = res_data;
          sat_d   = res_sat;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (bus.ready_in) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
      mode_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.busy_out  = busy_q;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = dout_q;
  assign bus.sat_out   = sat_q;
endmodule
